// File: rtl/fifo_stream_if.sv
// Signal bundle between the adapter, its upstream read-latency-1 FIFO and the downstream stream sink.
interface fifo_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_rddata;
  logic                  fifo_empty;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [15:0]           word_cnt;
  logic [15:0]           burst_cnt;
  logic                  busy;

  modport master (
    output fifo_rden,
    input  fifo_rddata, fifo_empty, flush,
    output m_valid,
    input  m_ready,
    output m_data, m_last, word_cnt, burst_cnt, busy
  );

  modport slave (
    input  fifo_rden,
    output fifo_rddata, fifo_empty, flush,
    input  m_valid,
    output m_ready,
    input  m_data, m_last, word_cnt, burst_cnt, busy
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream with a 2-entry skid buffer,
// burst framing (m_last), beat/burst counters and a synchronous flush.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic           clk,
  input  logic           rst,
  fifo_stream_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [15:0]           beat_idx_q, beat_idx_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;

  logic pop;
  logic capture;
  logic to_head;
  logic at_last;
  logic rden;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    beat_idx_d  = beat_idx_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;

    pop     = (occ_q != 2'd0) && bus.m_ready;
    at_last = (beat_idx_q == LAST_IDX);
    // Returning read data is dropped if a flush lands in the same cycle.
    capture = inflight_q && !bus.flush;
    to_head = (occ_q == 2'd0) || ((occ_q == 2'd1) && pop);
    rden    = !rst && !bus.fifo_empty && !bus.flush && (state_q != FLUSH) &&
              (({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    inflight_d = rden;

    if (pop) begin
      head_d     = tail_q;
      beat_idx_d = at_last ? 16'd0 : beat_idx_q + 16'd1;
      if (!bus.flush) begin
        word_cnt_d = word_cnt_q + 16'd1;
        if (at_last) burst_cnt_d = burst_cnt_q + 16'd1;
      end
    end

    if (capture) begin
      if (to_head) head_d = bus.fifo_rddata;
      else         tail_d = bus.fifo_rddata;
    end
    occ_d = occ_q - 2'(pop) + 2'(capture);

    if (bus.flush) begin
      occ_d      = 2'd0;
      beat_idx_d = 16'd0;
      state_d    = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
    end else begin
      state_d = ((occ_d != 2'd0) || inflight_d) ? ACTIVE : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      // NOTE: the buffer storage is reset too, because m_data is read straight off the head entry.
      head_q      <= '0;
      tail_q      <= '0;
      beat_idx_q  <= 16'd0;
      word_cnt_q  <= 16'd0;
      burst_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      beat_idx_q  <= beat_idx_d;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.fifo_rden = rden;
  assign bus.m_valid   = (occ_q != 2'd0);
  assign bus.m_data    = head_q;
  assign bus.m_last    = (occ_q != 2'd0) && at_last;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.burst_cnt = burst_cnt_q;
  assign bus.busy      = (occ_q != 2'd0) || inflight_q;
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a queue-level model of the word stream, checked every cycle,
// plus directed scenarios with hand-computed results (stream, backpressure, empty, reset, flush, wrap).
module tb_fifo_stream_adapter;
  localparam int DW = 32;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_if #(.DATA_WIDTH(DW)) bus ();
  fifo_stream_if #(.DATA_WIDTH(DW)) bus1 ();

  fifo_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fifo_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each word read from the FIFO becomes visible 2 cycles later, leaves in order on a handshake.
  typedef struct {logic [31:0] data; int avail;} entry_t;
  typedef struct {logic [31:0] data; logic last; int cyc;} beat_t;

  entry_t      exp_q[$];
  logic [31:0] fifo_q[$];
  beat_t       hs_log[$];
  int          cyc = 0;
  int          beat_m = 0;
  logic [15:0] words_m = 16'd0;
  logic [15:0] bursts_m = 16'd0;
  bit          flush_st = 1'b0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_word = 32'd0;
  int          first_rden_cyc = -1;
  int          first_valid_cyc = -1;

  always @(negedge clk) begin
    bit          exp_valid;
    bit          pop;
    bit          exp_rden;
    logic [31:0] w;
    cyc++;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    pop       = exp_valid && bus.m_ready;
    exp_rden  = !rst && !bus.fifo_empty && !bus.flush && !flush_st && ((exp_q.size() - int'(pop)) < 2);

    check("fifo_rden", bus.fifo_rden, exp_rden);
    check("rden_while_empty", bus.fifo_rden & bus.fifo_empty, 0);
    check("occupancy_le_2", exp_q.size() <= 2, 1);
    if (!rst) begin
      check("m_valid", bus.m_valid, exp_valid);
      if (exp_valid) check("m_data", bus.m_data, exp_q[0].data);
      check("m_last", bus.m_last, exp_valid && (beat_m == BL - 1));
      check("word_cnt", bus.word_cnt, words_m);
      check("burst_cnt", bus.burst_cnt, bursts_m);
      check("busy", bus.busy, exp_q.size() != 0);
    end

    if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (rst) begin
      exp_q.delete();
      beat_m   = 0;
      words_m  = 16'd0;
      bursts_m = 16'd0;
      flush_st = 1'b0;
    end else begin
      if (pop) begin
        if (!bus.flush) begin
          hs_log.push_back('{data: exp_q[0].data, last: (beat_m == BL - 1), cyc: cyc});
          words_m++;
          if (beat_m == BL - 1) bursts_m++;
          beat_m = (beat_m + 1) % BL;
        end
        void'(exp_q.pop_front());
      end
      if (bus.fifo_rden) begin
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
        check("fifo_underflow", fifo_q.size() > 0, 1);
        w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
        rd_pending = 1'b1;
        rd_word    = w;
        exp_q.push_back('{data: w, avail: cyc + 2});
      end
      if (bus.flush) begin
        exp_q.delete();
        beat_m = 0;
      end
      flush_st = bus.flush;
    end
  end

  // Upstream FIFO: data valid the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    #1;
    bus.fifo_rddata = rd_pending ? rd_word : 32'hDEAD_BEEF;
    rd_pending      = 1'b0;
    bus.fifo_empty  = (fifo_q.size() == 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hs_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("handshake_wait", hs_log.size() >= n, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    bit seen_ffff;
    rst = 1'b1;
    bus.fifo_empty  = 1'b1;
    bus.fifo_rddata = 32'd0;
    bus.flush       = 1'b0;
    bus.m_ready     = 1'b0;
    bus1.fifo_empty  = 1'b1;
    bus1.fifo_rddata = 32'd0;
    bus1.flush       = 1'b0;
    bus1.m_ready     = 1'b0;

    // Reset values
    tick(3);
    rst = 1'b0;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_word_cnt", bus.word_cnt, 0);
    check("rst_burst_cnt", bus.burst_cnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rden", bus.fifo_rden, 0);
    check("rst1_m_valid", bus1.m_valid, 0);

    // Stream: 16 words, ready held high
    hs_log.delete();
    first_rden_cyc  = -1;
    first_valid_cyc = -1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'(i));
    bus.m_ready = 1'b1;
    wait_hs(16, 100);
    tick(2);
    check("stream_beats", hs_log.size(), 16);
    for (int i = 0; i < 16 && i < hs_log.size(); i++) begin
      check("stream_data", hs_log[i].data, 32'(i));
      check("stream_last", hs_log[i].last, (i == 7) || (i == 15));
    end
    if (hs_log.size() == 16) check("stream_back_to_back", hs_log[15].cyc - hs_log[0].cyc, 15);
    check("first_valid_latency", first_valid_cyc - first_rden_cyc, 2);
    check("stream_word_cnt", bus.word_cnt, 16);
    check("stream_burst_cnt", bus.burst_cnt, 2);

    // Backpressure: 100 words, ready toggled randomly
    hs_log.delete();
    for (int i = 0; i < 100; i++) fifo_q.push_back(32'(100 + i));
    for (k = 0; k < 1000 && hs_log.size() < 100; k++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.m_ready = 1'b1;
    wait_hs(100, 20);
    tick(2);
    check("bp_beats", hs_log.size(), 100);
    for (int i = 0; i < 100 && i < hs_log.size(); i++) check("bp_order", hs_log[i].data, 32'(100 + i));
    check("bp_word_cnt", bus.word_cnt, 116);
    check("bp_burst_cnt", bus.burst_cnt, 14);

    // Empty edge: a single word then empty
    hs_log.delete();
    fifo_q.push_back(32'hA5A5_0001);
    wait_hs(1, 20);
    check("single_data", (hs_log.size() > 0) ? hs_log[0].data : 32'h0, 32'hA5A5_0001);
    check("single_busy_drop", bus.busy, 0);
    check("single_m_valid", bus.m_valid, 0);
    check("single_word_cnt", bus.word_cnt, 117);
    tick(2);
    check("single_one_beat", hs_log.size(), 1);

    // Reset mid-burst with a read in flight
    hs_log.delete();
    bus.m_ready    = 1'b0;
    first_rden_cyc = -1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hB000_0000 + 32'(i));
    k = 0;
    while (first_rden_cyc < 0 && k < 20) begin
      tick();
      k++;
    end
    check("rst_test_rden_seen", first_rden_cyc >= 0, 1);
    rst = 1'b1;
    #1;
    check("rst_hold_rden", bus.fifo_rden, 0);
    tick();
    rst = 1'b0;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_m_data", bus.m_data, 0);
    check("midrst_m_last", bus.m_last, 0);
    check("midrst_word_cnt", bus.word_cnt, 0);
    check("midrst_burst_cnt", bus.burst_cnt, 0);
    check("midrst_busy", bus.busy, 0);
    bus.m_ready = 1'b1;
    wait_hs(3, 30);
    tick(3);
    check("midrst_beats", hs_log.size(), 3);
    for (int i = 0; i < 3 && i < hs_log.size(); i++)
      check("midrst_drop_first", hs_log[i].data, 32'hB000_0001 + 32'(i));
    check("midrst_word_cnt_after", bus.word_cnt, 3);

    // Flush after 5 beats of a burst with data still buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hs_log.delete();
    for (int i = 0; i < 7; i++) fifo_q.push_back(32'hC000_0000 + 32'(i));
    bus.m_ready = 1'b1;
    wait_hs(5, 40);
    bus.m_ready = 1'b0;
    tick(3);
    check("pre_flush_buffered", bus.m_valid, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_cycle1_valid", bus.m_valid, 0);
    tick(3);
    check("flush_word_cnt", bus.word_cnt, 5);
    check("flush_burst_cnt", bus.burst_cnt, 0);
    check("flush_no_valid", bus.m_valid, 0);
    check("flush_beats", hs_log.size(), 5);
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hD000_0000 + 32'(i));
    bus.m_ready = 1'b1;
    wait_hs(13, 60);
    tick(2);
    check("post_flush_beats", hs_log.size(), 13);
    if (hs_log.size() == 13) begin
      check("post_flush_first", hs_log[5].data, 32'hD000_0000);
      check("post_flush_last_early", hs_log[11].last, 0);
      check("post_flush_last", hs_log[12].last, 1);
      check("post_flush_data", hs_log[12].data, 32'hD000_0007);
    end
    check("post_flush_word_cnt", bus.word_cnt, 13);
    check("post_flush_burst_cnt", bus.burst_cnt, 1);

    // Counter wrap: 65536 beats with BURST_LEN=1
    n = 0;
    seen_ffff = 1'b0;
    bus1.fifo_empty = 1'b0;
    bus1.m_ready    = 1'b1;
    k = 0;
    while (n < 65536 && k < 70000) begin
      @(negedge clk);
      k++;
      if (n == 65535 && !seen_ffff) begin
        seen_ffff = 1'b1;
        check("wrap_word_cnt_ffff", bus1.word_cnt, 16'hFFFF);
        check("wrap_burst_cnt_ffff", bus1.burst_cnt, 16'hFFFF);
      end
      if (bus1.m_valid && bus1.m_ready) begin
        check("wrap_last_every_beat", bus1.m_last, 1);
        n++;
      end
    end
    @(posedge clk);
    #1;
    bus1.m_ready    = 1'b0;
    bus1.fifo_empty = 1'b1;
    tick(3);
    check("wrap_beats", n, 65536);
    check("wrap_word_cnt", bus1.word_cnt, 0);
    check("wrap_burst_cnt", bus1.burst_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stream_adapter.md
FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 SHALL have parameter BURST_LEN, default 8, beats per burst; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fifo_rden  output  1  read strobe to upstream FIFO.
REQ-006 SHALL have port fifo_rddata  input  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after fifo_rden.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-009 SHALL have port m_valid  output  1  stream beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  stream beat data.
REQ-012 SHALL have port m_last  output  1  final beat of current burst.
REQ-013 SHALL have port word_cnt  output  16  beats accepted since reset, wraps 0xFFFF->0.
REQ-014 SHALL have port burst_cnt  output  16  bursts completed since reset, wraps 0xFFFF->0.
REQ-015 SHALL have port busy  output  1  high when buffer non-empty or a read is in flight.

Function
REQ-016 SHALL hold a 2-entry in-order output buffer; m_data/m_valid SHALL come from the head entry.
REQ-017 SHALL track in-flight reads (0 or 1) and occupancy (0..2) registered.
REQ-018 SHALL assert fifo_rden only when !fifo_empty, !flush, state != FLUSH, and (occupancy + inflight - pop) < 2, where pop = m_valid && m_ready in that cycle.
REQ-019 SHALL never assert fifo_rden while fifo_empty is high.
REQ-020 SHALL write fifo_rddata into the buffer tail in the cycle after fifo_rden, unless discarded per REQ-027.
REQ-021 SHALL sustain one beat per cycle when FIFO non-empty and m_ready held high; first m_valid 2 cycles after first fifo_rden-eligible cycle (rden cycle + data-capture cycle).
REQ-022 SHALL hold m_valid and m_data stable while m_valid && !m_ready (no drop, no reorder).
REQ-023 SHALL keep a beat index 0..BURST_LEN-1, incremented on each handshake, wrapping to 0 after BURST_LEN-1; m_last = m_valid && (beat index == BURST_LEN-1); BURST_LEN=1 gives m_last on every beat.
REQ-024 SHALL increment word_cnt on every handshake and burst_cnt on every handshake with m_last high.
REQ-025 SHALL implement states IDLE (occupancy 0, inflight 0), ACTIVE (otherwise), FLUSH.
REQ-026 SHALL transition IDLE->ACTIVE on fifo_rden; ACTIVE->IDLE when occupancy and inflight both reach 0; any state->FLUSH on flush; FLUSH->IDLE after exactly one cycle with flush low.
REQ-027 On flush SHALL, next edge, clear occupancy and beat index, and discard the read data returning in the following cycle; m_valid SHALL be 0 in flush cycle+1 and in FLUSH state.
REQ-028 SHALL not count a handshake coincident with flush high; word_cnt/burst_cnt otherwise unaffected by flush.
REQ-029 Simultaneous pop and data capture with occupancy 2 SHALL not occur (guaranteed by REQ-018); with occupancy 1 SHALL leave occupancy 1 with new data at head.
REQ-030 busy SHALL equal (occupancy != 0) || inflight.

Reset
REQ-031 On rst high SHALL, next edge, force fifo_rden=0, m_valid=0, m_last=0, m_data=0, word_cnt=0, burst_cnt=0, busy=0, occupancy=0, inflight=0, beat index=0, state=IDLE.
REQ-032 Reset mid-operation SHALL discard buffered and in-flight data; read data arriving the cycle after reset deassertion from a pre-reset rden SHALL be dropped.
REQ-033 rst SHALL take priority over flush and all other inputs.

Verification
REQ-034 Stream: FIFO holds 16 words 0..15, m_ready=1, BURST_LEN=8 -> 16 consecutive beats 0..15, m_last on beats 7 and 15, word_cnt=16, burst_cnt=2.
REQ-035 Backpressure: m_ready toggles randomly 50% over 100 words -> output order exact, m_data stable while stalled, no fifo_rden while empty, occupancy never >2.
REQ-036 Empty edge: FIFO supplies 1 word then empty -> single beat, busy drops to 0 one cycle after handshake, state IDLE.
REQ-037 Flush: 5 words delivered of burst, m_ready=0, flush pulse -> no further beats from pre-flush data, next beat has beat index 0, word_cnt=5.
REQ-038 Reset mid-burst: rst asserted 1 cycle during read with inflight=1 -> all outputs at reset values, returning word dropped, counters 0.
REQ-039 Wrap: 65536 beats with BURST_LEN=1 -> word_cnt=0 and burst_cnt=0 after final beat.
